// File: rtl/switch_debouncer.sv
// Three-channel switch conditioner: multi-flop synchronizer, per-channel debounce FSM,
// registered level plus single-cycle rise/fall strobes, optional push-button toggle on channel 0.
//
// state     | meaning
// STABLE_LO | debounced level is 0, watching for sync=1
// PEND_HI   | sync went high, counting stable samples before accepting a rise
// STABLE_HI | debounced level is 1, watching for sync=0
// PEND_LO   | sync went low, counting stable samples before accepting a fall
module switch_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          TOGGLE_CH0      = 1'b0
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [2:0] i_raw,
  output logic [2:0] o_level,
  output logic [2:0] o_rise,
  output logic [2:0] o_fall
);

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  logic [NUM_CH-1:0] sync;
  logic [NUM_CH-1:0] deb;
  logic [NUM_CH-1:0] rise_q;
  logic [NUM_CH-1:0] fall_q;
  logic [NUM_CH-1:0] rise_evt;
  logic              tog;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_ff;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   ch_deb;
    logic                   ch_rise;
    logic                   ch_fall;

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        sync_ff <= '0;
      end else begin
        sync_ff <= {sync_ff[SYNC_STAGES-2:0], i_raw[ch]};
      end
    end

    assign sync[ch] = sync_ff[SYNC_STAGES-1];

    // The counter is compared before it increments, so it tops out at CNT_LAST.
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        state   <= STABLE_LO;
        cnt     <= '0;
        ch_deb  <= 1'b0;
        ch_rise <= 1'b0;
        ch_fall <= 1'b0;
      end else begin
        ch_rise <= 1'b0;
        ch_fall <= 1'b0;
        case (state)
          STABLE_LO: begin
            if (sync[ch]) begin
              state <= PEND_HI;
              cnt   <= '0;
            end
          end
          PEND_HI: begin
            if (!sync[ch]) begin
              state <= STABLE_LO;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= STABLE_HI;
              ch_deb  <= 1'b1;
              ch_rise <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          STABLE_HI: begin
            if (!sync[ch]) begin
              state <= PEND_LO;
              cnt   <= '0;
            end
          end
          PEND_LO: begin
            if (sync[ch]) begin
              state <= STABLE_HI;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= STABLE_LO;
              ch_deb  <= 1'b0;
              ch_fall <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= STABLE_LO;
            cnt   <= '0;
          end
        endcase
      end
    end

    // Same condition that sets ch_rise, so the toggle flips on the strobe edge.
    assign rise_evt[ch] = (state == PEND_HI) && sync[ch] && (cnt == CNT_LAST);

    assign deb[ch]    = ch_deb;
    assign rise_q[ch] = ch_rise;
    assign fall_q[ch] = ch_fall;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tog <= 1'b0;
    end else if (TOGGLE_CH0 && rise_evt[0]) begin
      tog <= ~tog;
    end
  end

  assign o_level = {deb[2:1], (TOGGLE_CH0 ? tog : deb[0])};
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2;
// a second instance runs channel 0 in toggle mode off the same stimulus.
module tb_switch_debouncer;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic [2:0] i_raw;
  logic [2:0] lvl, rise, fall;
  logic [2:0] lvl_t, rise_t, fall_t;

  int n_checks = 0;
  int n_fail   = 0;

  always #20 i_clock = ~i_clock;

  switch_debouncer #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .TOGGLE_CH0(1'b0)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_raw   (i_raw),
    .o_level (lvl),
    .o_rise  (rise),
    .o_fall  (fall)
  );

  switch_debouncer #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .TOGGLE_CH0(1'b1)) dut_t (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_raw   (i_raw),
    .o_level (lvl_t),
    .o_rise  (rise_t),
    .o_fall  (fall_t)
  );

  typedef struct {
    logic [2:0] raw;
    logic [2:0] lvl;
    logic [2:0] rise;
    logic [2:0] fall;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_n(input int n, input logic [2:0] r, l, ri, f);
    vec_t v;
    v.raw  = r;
    v.lvl  = l;
    v.rise = ri;
    v.fall = f;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] el, er, ef, elt, ert, eft);
    check({tag, " level"},   lvl,    el);
    check({tag, " rise"},    rise,   er);
    check({tag, " fall"},    fall,   ef);
    check({tag, " level_t"}, lvl_t,  elt);
    check({tag, " rise_t"},  rise_t, ert);
    check({tag, " fall_t"},  fall_t, eft);
  endtask

  // Inputs change 1 time unit after an edge; outputs are read at the same point.
  task automatic tick(input logic [2:0] raw, input logic rst);
    i_raw   = raw;
    i_reset = rst;
    @(posedge i_clock);
    #1;
  endtask

  // Hold raw from edge 0; outputs must be steady until edge ev, strobe there, then hold.
  task automatic phase(input string tag, input logic [2:0] raw, input int ev,
                       input logic [2:0] l0, l1, lt0, lt1, rs, fs);
    for (int j = 0; j <= ev + 1; j++) begin
      tick(raw, 1'b0);
      if (j < ev)
        check_all($sformatf("%s[%0d]", tag, j), l0, 3'b000, 3'b000, lt0, 3'b000, 3'b000);
      else if (j == ev)
        check_all($sformatf("%s[%0d]", tag, j), l1, rs, fs, lt1, rs, fs);
      else
        check_all($sformatf("%s[%0d]", tag, j), l1, 3'b000, 3'b000, lt1, 3'b000, 3'b000);
    end
  endtask

  initial begin
    // ch1 clean rise at edge 6; ch2 high 4 cycles is rejected
    add_n(4, 3'b110, 3'b000, 3'b000, 3'b000);
    add_n(2, 3'b010, 3'b000, 3'b000, 3'b000);
    add_n(1, 3'b010, 3'b010, 3'b010, 3'b000);
    add_n(3, 3'b010, 3'b010, 3'b000, 3'b000);
    // ch2 high 5 cycles: accepted at edge 6, released at edge 11
    add_n(5, 3'b110, 3'b010, 3'b000, 3'b000);
    add_n(1, 3'b010, 3'b010, 3'b000, 3'b000);
    add_n(1, 3'b010, 3'b110, 3'b100, 3'b000);
    add_n(4, 3'b010, 3'b110, 3'b000, 3'b000);
    add_n(1, 3'b010, 3'b010, 3'b000, 3'b100);
    add_n(1, 3'b010, 3'b010, 3'b000, 3'b000);
    // ch1 released
    add_n(6, 3'b000, 3'b010, 3'b000, 3'b000);
    add_n(1, 3'b000, 3'b000, 3'b000, 3'b010);
    add_n(1, 3'b000, 3'b000, 3'b000, 3'b000);

    i_reset = 1'b1;
    i_raw   = 3'b111;

    for (int k = 0; k < 3; k++) begin
      tick(3'b111, 1'b1);
      check_all($sformatf("reset[%0d]", k), 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    end

    // inputs held high through reset still need full qualification
    phase("release", 3'b111, 6, 3'b000, 3'b111, 3'b000, 3'b111, 3'b111, 3'b000);
    phase("drop_all", 3'b000, 6, 3'b111, 3'b000, 3'b111, 3'b001, 3'b000, 3'b111);

    tick(3'b000, 1'b1);
    check_all("reset2", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

    for (int k = 0; k < vecs.size(); k++) begin
      tick(vecs[k].raw, 1'b0);
      check_all($sformatf("vec[%0d]", k), vecs[k].lvl, vecs[k].rise, vecs[k].fall,
                vecs[k].lvl, vecs[k].rise, vecs[k].fall);
    end

    // bounce 1,0,1,1,0 then steady 1: a single rise six edges after the steady level starts
    begin
      logic [4:0] bounce;
      bounce = 5'b01101;
      for (int k = 0; k < 5; k++) begin
        tick({2'b00, bounce[k]}, 1'b0);
        check_all($sformatf("bounce_pre[%0d]", k), 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
      end
    end
    phase("bounce", 3'b001, 6, 3'b000, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000);

    // toggle channel holds across releases and flips back on the second press
    phase("rel1",   3'b000, 6, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001);
    phase("press2", 3'b001, 6, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001, 3'b000);
    phase("rel2",   3'b000, 6, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001);

    phase("simul_rise", 3'b111, 6, 3'b000, 3'b111, 3'b000, 3'b111, 3'b111, 3'b000);
    phase("simul_fall", 3'b000, 6, 3'b111, 3'b000, 3'b111, 3'b001, 3'b000, 3'b111);

    tick(3'b000, 1'b1);
    check_all("reset3", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

    // ch1 is mid-PEND_HI when reset hits; qualification restarts after release
    for (int k = 0; k < 4; k++) begin
      tick(3'b010, 1'b0);
      check_all($sformatf("pend[%0d]", k), 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    end
    tick(3'b010, 1'b1);
    check_all("pend_reset", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    phase("pend_restart", 3'b010, 6, 3'b000, 3'b010, 3'b000, 3'b010, 3'b010, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Conditions the board's raw slide switches and push button before they reach the LED blinker's enable and rate-select inputs. Each of three channels passes through a multi-flop synchronizer and then a per-channel debounce state machine, giving a clean level plus single-cycle rise and fall strobes. Channel 0 can optionally run as a push-button toggle, so a momentary button drives the blinker's enable.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 250000: number of consecutive extra stable samples required, which is 10 ms at 25 MHz. Legal values are 2 or more.
- SYNC_STAGES, default 2: synchronizer depth. Legal values are 2 or more.
- TOGGLE_CH0, default 0: when 1, o_level[0] flips on each debounced rise of channel 0 instead of following it.

Ports:
- i_clock, input, 1 bit: the single clock for the block, 25 MHz.
- i_reset, input, 1 bit: synchronous, active-high reset.
- i_raw, input, 3 bits: asynchronous switch inputs. Bit 0 is enable, bit 1 is switch_1, bit 2 is switch_2.
- o_level, output, 3 bits: debounced levels, or the toggle state on bit 0 when TOGGLE_CH0 is 1.
- o_rise, output, 3 bits: one-cycle strobe when a channel's debounced level goes 0→1.
- o_fall, output, 3 bits: one-cycle strobe when a channel's debounced level goes 1→0.

## Operation
- **Synchronizer:** per channel, a chain of SYNC_STAGES flops. Its last stage, called sync[i], is the only value the FSM reads.
- **Per-channel FSM:** four states, STABLE_LO, PEND_HI, STABLE_HI and PEND_LO. Each channel has a counter of width clog2(DEBOUNCE_CYCLES).
- **From STABLE_LO:** if sync=1, go to PEND_HI and load cnt=0. Otherwise stay.
- **From PEND_HI:**
  - if sync=0, this is a glitch: return to STABLE_LO with cnt=0 and no strobe;
  - else if cnt==DEBOUNCE_CYCLES-1, go to STABLE_HI, set deb=1 and assert o_rise for one cycle;
  - else cnt+1.
- **STABLE_HI and PEND_LO:** mirror image of the above, ending with deb=0 and an o_fall strobe.
- **Counter wrap:** the counter never wraps. It saturates by construction because it is compared against DEBOUNCE_CYCLES-1 before incrementing.
- **Acceptance rule:** a change is accepted only if sync holds the new value for DEBOUNCE_CYCLES+1 consecutive FSM samples.
- **Glitch restart:** any glitch restarts qualification from zero on the next change.
- **Output selection:**
  - o_level[i] = deb[i] for all channels when TOGGLE_CH0=0, and for channels 1-2 always.
  - When TOGGLE_CH0=1, o_level[0] = tog. The tog register inverts on the same edge that o_rise[0] asserts.
  - o_fall[0] has no effect on tog.
- **Strobe source:** o_rise and o_fall always reflect deb, regardless of TOGGLE_CH0.
- **Channel independence:** channels are fully independent. Simultaneous transitions on several channels produce simultaneous strobes.
- **Reset values:** all synchronizer flops 0, all FSMs in STABLE_LO, cnt=0, deb=0, tog=0. Therefore o_level=3'b000, o_rise=3'b000 and o_fall=3'b000.
- **Reset mid-qualification:** any pending qualification is discarded.
- **Input held high through reset:** after reset deasserts, a raw input held at 1 goes through full synchronization and debounce before o_level rises. Nothing is preloaded.

## Timing
- All outputs are registered and change only on the rising edge of i_clock.
- **Latency:** raw stable before edge n puts the FSM in PEND at edge n+SYNC_STAGES. o_level and its strobe update at edge n+SYNC_STAGES+DEBOUNCE_CYCLES.
- **Minimum accepted pulse width:** DEBOUNCE_CYCLES+1 clocks of stable raw input. Anything shorter produces no output change and no strobe.
- **Strobe width:** exactly one cycle.
- **Strobe alignment:** a strobe is coincident with the o_level change, or with the tog flip when toggle mode is active.
- **Reset:** i_reset is sampled at the edge. Outputs read the reset values from the edge where i_reset=1. The FSM resumes on the first edge where i_reset=0.
- The downstream blinker may consume o_level directly on the same clock. No handshake is used.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2, and cycle counts refer to edges of i_clock.

1. **Reset:** hold i_reset for 3 cycles with i_raw=3'b111 → o_level, o_rise and o_fall read 0. After release, o_level reads 3'b111 at release-edge+6.
2. **Clean rise:** i_raw[1] goes to 1 before edge 10 and holds → o_level[1]=1 and o_rise[1]=1 at edge 16. o_rise[1]=0 at edge 17.
3. **Glitch rejection:**
   - i_raw[2] high for exactly 4 cycles (edges 10-13) → no change on o_level[2] and no strobe.
   - High for 5 cycles (edges 10-14) → o_level[2] rises at edge 16, then falls at edge 21 with o_fall[2].
4. **Bounce:** i_raw[0] pattern 1,0,1,1,0,1 followed by a steady 1 starting before edge 20 → exactly one o_rise[0], at edge 26.
5. **Toggle mode:** with TOGGLE_CH0=1, give two clean press/release cycles on i_raw[0] → o_level[0] goes 0→1 at the first rise and 1→0 at the second. It does not change at the releases, while o_fall[0] still pulses at each release.
6. **Simultaneous changes and mid-pend reset:**
   - All three raw inputs rise together → all three strobes fire on the same edge.
   - Assert i_reset while channel 1 is in PEND_HI → no strobe, and qualification restarts from zero after release.
